// File: rtl/aes_decipher_block.sv
// Iterative AES inverse cipher with one 32-bit inverse S-box word per cycle.
// Optional macro AES_DEC_FAST_SBOX_EN: 128-bit S-box port, one SBOX cycle per round.
module aes_decipher_block (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
`ifdef AES_DEC_FAST_SBOX_EN
  output logic [127:0] inv_sboxw,
  input  logic [127:0] new_inv_sboxw,
`else
  output logic [31:0]  inv_sboxw,
  input  logic [31:0]  new_inv_sboxw,
`endif
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t      fsm;
  logic [31:0] w0, w1, w2, w3;
`ifndef AES_DEC_FAST_SBOX_EN
  logic [1:0]  wcnt;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] b [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      b[i]  = w[31-8*i -: 8];
      x2    = xt(b[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ b[i];
      mb[i] = x8 ^ x2 ^ b[i];
      md[i] = x8 ^ x4 ^ b[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    return {inv_mix_word(s[127:96]), inv_mix_word(s[95:64]),
            inv_mix_word(s[63:32]),  inv_mix_word(s[31:0])};
  endfunction

  // Row r of column c comes from column c-r: bytes move right as rows go down.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [31:0] c0, c1, c2, c3;
    {c0, c1, c2, c3} = s;
    return {c0[31:24], c3[23:16], c2[15:8], c1[7:0],
            c1[31:24], c0[23:16], c3[15:8], c2[7:0],
            c2[31:24], c1[23:16], c0[15:8], c3[7:0],
            c3[31:24], c2[23:16], c1[15:8], c0[7:0]};
  endfunction

  logic [127:0] state_key;
  logic [127:0] round_next;
  logic [127:0] init_next;

  assign new_block  = {w0, w1, w2, w3};
  assign state_key  = new_block ^ round_key;
  assign round_next = inv_shift_rows(inv_mix_cols(state_key));
  assign init_next  = inv_shift_rows(block ^ round_key);

`ifdef AES_DEC_FAST_SBOX_EN
  always_comb begin
    inv_sboxw = '0;
    if (fsm == SBOX)
      inv_sboxw = new_block;
  end
`else
  always_comb begin
    inv_sboxw = '0;
    if (fsm == SBOX) begin
      case (wcnt)
        2'd0:    inv_sboxw = w0;
        2'd1:    inv_sboxw = w1;
        2'd2:    inv_sboxw = w2;
        default: inv_sboxw = w3;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm   <= IDLE;
      ready <= 1'b1;
      round <= 4'd0;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      w3    <= '0;
`ifndef AES_DEC_FAST_SBOX_EN
      wcnt  <= 2'd0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (next) begin
            // keylen 3 falls through to the AES-192 round count
            case (keylen)
              2'd0:    round <= 4'd10;
              2'd2:    round <= 4'd14;
              default: round <= 4'd12;
            endcase
            ready <= 1'b0;
            fsm   <= INIT;
          end
        end
        INIT: begin
          {w0, w1, w2, w3} <= init_next;
          round <= round - 4'd1;
`ifndef AES_DEC_FAST_SBOX_EN
          wcnt  <= 2'd0;
`endif
          fsm   <= SBOX;
        end
        SBOX: begin
`ifdef AES_DEC_FAST_SBOX_EN
          {w0, w1, w2, w3} <= new_inv_sboxw;
          fsm <= MAIN;
`else
          case (wcnt)
            2'd0:    w0 <= new_inv_sboxw;
            2'd1:    w1 <= new_inv_sboxw;
            2'd2:    w2 <= new_inv_sboxw;
            default: w3 <= new_inv_sboxw;
          endcase
          wcnt <= wcnt + 2'd1;
          if (wcnt == 2'd3)
            fsm <= MAIN;
`endif
        end
        MAIN: begin
`ifndef AES_DEC_FAST_SBOX_EN
          wcnt <= 2'd0;
`endif
          if (round != 4'd0) begin
            {w0, w1, w2, w3} <= round_next;
            round <= round - 4'd1;
            fsm   <= SBOX;
          end else begin
            {w0, w1, w2, w3} <= state_key;
            ready <= 1'b1;
            fsm   <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
